// File: rtl/fp_addsub_sched.sv
// Round-robin two-requester scheduler wrapped around a combinational IEEE-754 single add/sub.
// Stage A registers the granted operands, stage B registers the tagged result under backpressure.

module fp_addsub_dp (
    input  logic        i_mode,
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    output logic [31:0] o_result
);
    logic        sa, sb, eff_sub, swap, s_big;
    logic        a_nan, b_nan, a_inf, b_inf;
    logic [7:0]  ea_n, eb_n, e_big, e_small, diff, sh;
    logic [23:0] ma, mb, m_big, m_small;
    logic [49:0] small_ext;
    logic [26:0] aligned, norm;
    logic [27:0] sum;
    logic [4:0]  lz;
    logic [9:0]  exp_n, exp_f;
    logic        round_up;
    logic [30:0] rounded;

    assign sa      = i_a[31];
    assign sb      = i_b[31] ^ i_mode;
    assign eff_sub = sa ^ sb;
    assign a_nan   = (i_a[30:23] == 8'hFF) && (i_a[22:0] != '0);
    assign b_nan   = (i_b[30:23] == 8'hFF) && (i_b[22:0] != '0);
    assign a_inf   = (i_a[30:23] == 8'hFF) && (i_a[22:0] == '0);
    assign b_inf   = (i_b[30:23] == 8'hFF) && (i_b[22:0] == '0);

    // Subnormals use exponent 1 with no hidden bit.
    assign ea_n = (i_a[30:23] == '0) ? 8'd1 : i_a[30:23];
    assign eb_n = (i_b[30:23] == '0) ? 8'd1 : i_b[30:23];
    assign ma   = {(i_a[30:23] != '0), i_a[22:0]};
    assign mb   = {(i_b[30:23] != '0), i_b[22:0]};

    assign swap    = i_b[30:0] > i_a[30:0];
    assign s_big   = swap ? sb : sa;
    assign e_big   = swap ? eb_n : ea_n;
    assign e_small = swap ? ea_n : eb_n;
    assign m_big   = swap ? mb : ma;
    assign m_small = swap ? ma : mb;
    assign diff    = e_big - e_small;

    // Aligned smaller operand carries guard, round and a sticky OR of everything below.
    assign small_ext = {m_small, 26'b0} >> diff;
    assign aligned   = {small_ext[49:24], |small_ext[23:0]};
    assign sum       = eff_sub ? ({1'b0, m_big, 3'b0} - {1'b0, aligned})
                               : ({1'b0, m_big, 3'b0} + {1'b0, aligned});

    always_comb begin
        lz = 5'd27;
        for (int unsigned i = 0; i < 27; i++) begin
            if (sum[i]) lz = 5'(26 - i);
        end
    end

    // Left shift is capped so the exponent never drops below 1 (gradual underflow).
    assign sh = ({3'b0, lz} < e_big) ? {3'b0, lz} : e_big - 8'd1;

    always_comb begin
        if (sum[27]) begin
            norm  = {sum[27:2], sum[1] | sum[0]};
            exp_n = {2'b0, e_big} + 10'd1;
        end else begin
            norm  = sum[26:0] << sh;
            exp_n = {2'b0, e_big} - {2'b0, sh};
        end
    end

    assign exp_f    = norm[26] ? exp_n : '0;
    assign round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    // Carry out of the fraction bumps the exponent, also lifting a subnormal to normal.
    assign rounded  = {exp_f[7:0], norm[25:3]} + {30'b0, round_up};

    always_comb begin
        if (a_nan || b_nan || (a_inf && b_inf && eff_sub))
            o_result = 32'h7FC0_0000;
        else if (a_inf)
            o_result = {sa, 8'hFF, 23'b0};
        else if (b_inf)
            o_result = {sb, 8'hFF, 23'b0};
        else if (sum == '0)
            o_result = {(eff_sub ? 1'b0 : sa), 31'b0};
        else if (exp_f >= 10'd255)
            o_result = {s_big, 8'hFF, 23'b0};
        else
            o_result = {s_big, rounded};
    end
endmodule

module fp_addsub_sched #(
    parameter int unsigned RR_INIT = 0,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_req0_valid,
    output logic             o_req0_ready,
    input  logic             i_req0_mode,
    input  logic [31:0]      i_req0_a,
    input  logic [31:0]      i_req0_b,
    input  logic             i_req1_valid,
    output logic             o_req1_ready,
    input  logic             i_req1_mode,
    input  logic [31:0]      i_req1_a,
    input  logic [31:0]      i_req1_b,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [31:0]      o_res_data,
    output logic             o_res_id,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_grant_cnt0,
    output logic [CNT_W-1:0] o_grant_cnt1
);
    logic        a_valid, a_mode, a_id;
    logic [31:0] a_a, a_b;
    logic        ptr, grant;
    logic        b_load, a_adv, a_can_load;
    logic        acc0, acc1;
    logic [31:0] dp_result;

    fp_addsub_dp u_dp (
        .i_mode   (a_mode),
        .i_a      (a_a),
        .i_b      (a_b),
        .o_result (dp_result)
    );

    assign b_load     = ~o_res_valid | i_res_ready;
    assign a_adv      = a_valid & b_load;
    assign a_can_load = ~a_valid | a_adv;

    assign grant = (i_req0_valid & ~i_req1_valid) ? 1'b0 :
                   (i_req1_valid & ~i_req0_valid) ? 1'b1 : ptr;

    assign o_req0_ready = a_can_load & ~i_flush & ~grant;
    assign o_req1_ready = a_can_load & ~i_flush &  grant;
    assign acc0         = i_req0_valid & o_req0_ready;
    assign acc1         = i_req1_valid & o_req1_ready;
    assign o_busy       = a_valid | o_res_valid;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_valid      <= 1'b0;
            a_mode       <= 1'b0;
            a_id         <= 1'b0;
            a_a          <= '0;
            a_b          <= '0;
            o_res_valid  <= 1'b0;
            o_res_data   <= '0;
            o_res_id     <= 1'b0;
            ptr          <= RR_INIT[0];
            o_grant_cnt0 <= '0;
            o_grant_cnt1 <= '0;
        end else if (i_flush) begin
            a_valid     <= 1'b0;
            o_res_valid <= 1'b0;
        end else begin
            if (b_load) o_res_valid <= a_valid;
            if (a_adv) begin
                o_res_data <= dp_result;
                o_res_id   <= a_id;
            end
            if (acc0 | acc1) begin
                a_valid <= 1'b1;
                a_id    <= acc1;
                a_mode  <= acc1 ? i_req1_mode : i_req0_mode;
                a_a     <= acc1 ? i_req1_a : i_req0_a;
                a_b     <= acc1 ? i_req1_b : i_req0_b;
                ptr     <= ~acc1;
            end else if (a_adv) begin
                a_valid <= 1'b0;
            end
            if (acc0 && o_grant_cnt0 != '1) o_grant_cnt0 <= o_grant_cnt0 + 1'b1;
            if (acc1 && o_grant_cnt1 != '1) o_grant_cnt1 <= o_grant_cnt1 + 1'b1;
        end
    end
endmodule

// File: tb/tb_fp_addsub_sched.sv
// Self-checking bench for fp_addsub_sched: directed vectors, corner sequences and a randomized
// soak scored against a real-arithmetic FP model and a two-slot in-order scoreboard.

module tb_fp_addsub_sched;
    localparam int RR_INIT = 0;

    typedef struct {
        logic        mode;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic        id;
    } res_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    logic v0 = 1'b0, m0 = 1'b0, v1 = 1'b0, m1 = 1'b0;
    logic [31:0] a0 = '0, b0 = '0, a1 = '0, b1 = '0;
    logic r0, r1, res_valid, res_id, busy;
    logic res_ready = 1'b1;
    logic [31:0] res_data;
    logic [15:0] cnt0, cnt1;

    logic s_v1 = 1'b0, s_m1 = 1'b0;
    logic [31:0] s_a1 = '0, s_b1 = '0;
    logic s_r0, s_r1, s_res_valid, s_res_id, s_busy;
    logic [31:0] s_res_data;
    logic [1:0] s_cnt0, s_cnt1;

    int n_checks = 0;
    int n_err = 0;

    res_t        q[$];
    logic        m_ptr;
    int unsigned m_c0, m_c1;
    int          n_cons = 0;
    logic        ovr_en = 1'b0;
    logic [31:0] ovr_val = '0;

    always #5 clk = ~clk;

    fp_addsub_sched #(.RR_INIT(RR_INIT), .CNT_W(16)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush),
        .i_req0_valid(v0), .o_req0_ready(r0), .i_req0_mode(m0), .i_req0_a(a0), .i_req0_b(b0),
        .i_req1_valid(v1), .o_req1_ready(r1), .i_req1_mode(m1), .i_req1_a(a1), .i_req1_b(b1),
        .o_res_valid(res_valid), .i_res_ready(res_ready), .o_res_data(res_data),
        .o_res_id(res_id), .o_busy(busy), .o_grant_cnt0(cnt0), .o_grant_cnt1(cnt1)
    );

    fp_addsub_sched #(.RR_INIT(RR_INIT), .CNT_W(2)) u_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(1'b0),
        .i_req0_valid(1'b0), .o_req0_ready(s_r0), .i_req0_mode(1'b0), .i_req0_a(32'h0), .i_req0_b(32'h0),
        .i_req1_valid(s_v1), .o_req1_ready(s_r1), .i_req1_mode(s_m1), .i_req1_a(s_a1), .i_req1_b(s_b1),
        .o_res_valid(s_res_valid), .i_res_ready(1'b1), .o_res_data(s_res_data),
        .o_res_id(s_res_id), .o_busy(s_busy), .o_grant_cnt0(s_cnt0), .o_grant_cnt1(s_cnt1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact real arithmetic on the decoded values, then round-to-nearest-even to single.
    function automatic real to_real(input logic [31:0] x);
        logic [63:0] d;
        logic [10:0] e11;
        e11 = {3'b0, x[30:23]} + 11'd896;
        if (x[30:0] == '0) d = {x[31], 63'b0};
        else               d = {x[31], e11, x[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] from_real(input real r);
        logic [63:0] d;
        logic [10:0] e11;
        logic [30:0] mag;
        logic        up;
        d = $realtobits(r);
        if (d[62:0] == '0) return {d[63], 31'b0};
        e11 = d[62:52] - 11'd896;
        mag = {e11[7:0], d[51:29]};
        up  = d[28] & ((|d[27:0]) | d[29]);
        mag = mag + {30'b0, up};
        return {d[63], mag};
    endfunction

    function automatic logic [31:0] fp_ref(input logic mode, input logic [31:0] a, input logic [31:0] b);
        real ra, rb;
        ra = to_real(a);
        rb = to_real(b);
        return from_real(mode ? (ra - rb) : (ra + rb));
    endfunction

    function automatic logic [31:0] rnd_fp();
        logic [7:0] e;
        logic [31:0] f;
        if ($urandom_range(0, 15) == 0) return 32'h0;
        e = 8'($urandom_range(118, 136));
        f = $urandom;
        return {1'($urandom_range(0, 1)), e, f[22:0]};
    endfunction

    task automatic new_op(output logic m, output logic [31:0] a, output logic [31:0] b);
        m = 1'($urandom_range(0, 1));
        a = rnd_fp();
        b = ($urandom_range(0, 7) == 0) ? a : rnd_fp();
    endtask

    // Scoreboard: accepted-but-unconsumed ops form a two-slot in-order queue.
    logic g, can, er0, er1;
    res_t e;
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_ptr = RR_INIT[0];
            m_c0 = 0;
            m_c1 = 0;
        end else begin
            g   = (v0 && !v1) ? 1'b0 : (v1 && !v0) ? 1'b1 : m_ptr;
            can = (q.size() < 2) || res_ready;
            er0 = can && !flush && !g;
            er1 = can && !flush && g;
            check("ready", 32'({r1, r0}), 32'({er1, er0}));
            check("busy", 32'(busy), 32'(q.size() != 0));
            check("grant_cnt0", 32'(cnt0), m_c0);
            check("grant_cnt1", 32'(cnt1), m_c1);
            if (q.size() == 0) check("res_valid_idle", 32'(res_valid), 32'(0));
            if (res_valid && res_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL spurious_result: got %h expected none", res_data);
                end else begin
                    e = q.pop_front();
                    check("res_data", res_data, e.data);
                    check("res_id", 32'(res_id), 32'(e.id));
                    n_cons++;
                end
            end
            if (flush) q.delete();
            else begin
                if (v0 && r0) begin
                    q.push_back('{ovr_en ? ovr_val : fp_ref(m0, a0, b0), 1'b0});
                    m_c0++;
                    m_ptr = 1'b1;
                end
                if (v1 && r1) begin
                    q.push_back('{ovr_en ? ovr_val : fp_ref(m1, a1, b1), 1'b1});
                    m_c1++;
                    m_ptr = 1'b0;
                end
            end
        end
    end

    task automatic run_op(input int k, input vec_t v);
        ovr_en = 1'b1;
        ovr_val = v.exp;
        if (k == 0) begin m0 = v.mode; a0 = v.a; b0 = v.b; v0 = 1'b1; end
        else        begin m1 = v.mode; a1 = v.a; b1 = v.b; v1 = 1'b1; end
        @(negedge clk); check("op_ready", 32'(k == 0 ? r0 : r1), 32'(1));
        @(posedge clk); #1; v0 = 1'b0; v1 = 1'b0;
        @(negedge clk); check("op_t1_valid", 32'(res_valid), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        check("op_t2_valid", 32'(res_valid), 32'(1));
        check("op_data", res_data, v.exp);
        check("op_id", 32'(res_id), 32'(k));
        @(posedge clk); #1;
        ovr_en = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        v0 = 1'b0; v1 = 1'b0; flush = 1'b0; res_ready = 1'b1;
        n = 0;
        while (busy && n < 12) begin @(posedge clk); #1; n++; end
        check(name, 32'(busy), 32'(0));
    endtask

    vec_t tbl[14];
    logic acc0, acc1, have_ref, ptr_s;
    logic [31:0] ref_data;
    logic [15:0] c0s, c1s;
    int na, cons_s, nacc, ngot;
    logic [31:0] sq[$];

    initial begin
        tbl[0]  = '{1'b0, 32'h4000_0000, 32'h3F80_0000, 32'h4040_0000};
        tbl[1]  = '{1'b1, 32'h4000_0000, 32'h3F80_0000, 32'h3F80_0000};
        tbl[2]  = '{1'b1, 32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000};
        tbl[3]  = '{1'b1, 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000};
        tbl[4]  = '{1'b0, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000};
        tbl[5]  = '{1'b0, 32'h3F80_0000, 32'h33C0_0000, 32'h3F80_0001};
        tbl[6]  = '{1'b1, 32'h3F80_0000, 32'h3F7F_FFFF, 32'h3380_0000};
        tbl[7]  = '{1'b1, 32'h0080_0000, 32'h0000_0001, 32'h007F_FFFF};
        tbl[8]  = '{1'b0, 32'h7F80_0000, 32'h3F80_0000, 32'h7F80_0000};
        tbl[9]  = '{1'b1, 32'h7F80_0000, 32'h7F80_0000, 32'h7FC0_0000};
        tbl[10] = '{1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 32'h7F80_0000};
        tbl[11] = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
        tbl[12] = '{1'b0, 32'h3FC0_0000, 32'hC020_0000, 32'hBF80_0000};
        tbl[13] = '{1'b1, 32'h3F80_0001, 32'h3F80_0000, 32'h3400_0000};

        repeat (3) @(posedge clk);
        check("rst_res_valid", 32'(res_valid), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_cnt0", 32'(cnt0), 32'(0));
        #1 rst_n = 1'b1;
        #1 check("rst_ready", 32'({r1, r0}), 32'(2'b01));

        // Directed vectors, alternating requesters; first op also checks its grant count.
        @(posedge clk); #1;
        for (int i = 0; i < 14; i++) begin
            run_op(i % 2, tbl[i]);
            if (i == 0) check("single_cnt0", 32'(cnt0), 32'(1));
        end

        // Contention: both valid for 8 cycles.
        c0s = cnt0; c1s = cnt1;
        new_op(m0, a0, b0); new_op(m1, a1, b1);
        v0 = 1'b1; v1 = 1'b1; res_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 2) check("contend_b2b", 32'(res_valid), 32'(1));
            acc0 = v0 & r0; acc1 = v1 & r1;
            check("contend_order", 32'({acc1, acc0}), (i % 2 == 0) ? 32'(2'b01) : 32'(2'b10));
            @(posedge clk); #1;
            if (acc0) new_op(m0, a0, b0);
            if (acc1) new_op(m1, a1, b1);
        end
        v0 = 1'b0; v1 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); check("contend_tail", 32'(res_valid), 32'(1));
            @(posedge clk); #1;
        end
        check("contend_cnt0", 32'(cnt0 - c0s), 32'(4));
        check("contend_cnt1", 32'(cnt1 - c1s), 32'(4));
        drain("contend_drain");

        // Backpressure from requester 1.
        res_ready = 1'b0; v1 = 1'b1; new_op(m1, a1, b1);
        na = 0; have_ref = 1'b0; ref_data = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            acc1 = v1 & r1;
            if (acc1) na++;
            if (res_valid) begin
                if (!have_ref) begin ref_data = res_data; have_ref = 1'b1; end
                else check("bp_stable", res_data, ref_data);
            end
            @(posedge clk); #1;
            if (acc1) new_op(m1, a1, b1);
        end
        check("bp_accepts", 32'(na), 32'(2));
        @(negedge clk); check("bp_ready1", 32'(r1), 32'(0));
        @(posedge clk); #1;
        cons_s = n_cons;
        drain("bp_drain");
        check("bp_delivered", 32'(n_cons - cons_s), 32'(2));

        // Flush with both stages full and requester 0 still valid.
        res_ready = 1'b0; v0 = 1'b1; new_op(m0, a0, b0);
        repeat (2) begin @(posedge clk); #1; new_op(m0, a0, b0); end
        flush = 1'b1;
        c0s = cnt0; c1s = cnt1; ptr_s = m_ptr;
        @(negedge clk); check("flush_busy_before", 32'(busy), 32'(1));
        @(posedge clk); #1;
        flush = 1'b0; v0 = 1'b1; v1 = 1'b1;
        @(negedge clk);
        check("flush_res_valid", 32'(res_valid), 32'(0));
        check("flush_busy", 32'(busy), 32'(0));
        check("flush_cnt0", 32'(cnt0), 32'(c0s));
        check("flush_cnt1", 32'(cnt1), 32'(c1s));
        check("flush_ptr", 32'({r1, r0}), ptr_s ? 32'(2'b10) : 32'(2'b01));
        @(posedge clk); #1;
        drain("flush_drain");

        // Asynchronous reset mid-stream with both stages full.
        res_ready = 1'b0; v1 = 1'b1; new_op(m1, a1, b1);
        repeat (2) begin @(posedge clk); #1; new_op(m1, a1, b1); end
        v1 = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check("arst_res_valid", 32'(res_valid), 32'(0));
        check("arst_res_data", res_data, 32'(0));
        check("arst_res_id", 32'(res_id), 32'(0));
        check("arst_busy", 32'(busy), 32'(0));
        check("arst_cnts", 32'({cnt1, cnt0}), 32'(0));
        @(posedge clk); #1 rst_n = 1'b1;
        #1 check("arst_ready", 32'({r1, r0}), 32'(2'b01));
        res_ready = 1'b1;
        @(posedge clk); #1;

        // Randomized soak: random valids, backpressure and occasional flush.
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            acc0 = v0 & r0; acc1 = v1 & r1;
            @(posedge clk); #1;
            if (acc0 || !v0) begin v0 = ($urandom_range(0, 3) != 0); new_op(m0, a0, b0); end
            if (acc1 || !v1) begin v1 = ($urandom_range(0, 3) != 0); new_op(m1, a1, b1); end
            res_ready = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 39) == 0);
        end
        drain("soak_drain");
        check("soak_queue_empty", 32'(q.size()), 32'(0));

        // Saturation on the 2-bit counter instance.
        s_v1 = 1'b1; new_op(s_m1, s_a1, s_b1);
        nacc = 0; ngot = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (s_res_valid) begin
                if (sq.size() == 0) begin
                    n_checks++; n_err++;
                    $display("FAIL sat_spurious: got %h expected none", s_res_data);
                end else begin
                    check("sat_data", s_res_data, sq.pop_front());
                    check("sat_id", 32'(s_res_id), 32'(1));
                    ngot++;
                end
            end
            acc1 = s_v1 & s_r1;
            if (acc1) begin sq.push_back(fp_ref(s_m1, s_a1, s_b1)); nacc++; end
            @(posedge clk); #1;
            if (acc1) begin
                if (nacc == 5) s_v1 = 1'b0;
                else new_op(s_m1, s_a1, s_b1);
            end
        end
        check("sat_cnt1", 32'(s_cnt1), 32'(3));
        check("sat_cnt0", 32'(s_cnt0), 32'(0));
        check("sat_results", 32'(ngot), 32'(5));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
